// File: rtl/ip_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ip_fetch_pkg : shared constants, state encoding and helpers for ip_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ip_fetch_pkg;

  localparam int IADDR_WIDTH  = 10;
  localparam int INSN_WIDTH   = 16;
  localparam int RESET_VECTOR = 0;
  localparam int STAT_WIDTH   = 16;

  typedef enum logic [0:0] {
    ST_REQ   = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ip_fetch_if.sv
// ---------------------------------------------------------------------------
// ip_fetch_if : fetch-stage bundle (IP select, instruction memory, downstream)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ip_fetch_if #(
  parameter int IADDR_WIDTH = ip_fetch_pkg::IADDR_WIDTH,
  parameter int INSN_WIDTH  = ip_fetch_pkg::INSN_WIDTH
);
  import ip_fetch_pkg::*;

  logic [IADDR_WIDTH-1:0] IP;
  logic [IADDR_WIDTH-1:0] next_ip;
  logic [IADDR_WIDTH-1:0] imem_addr;
  logic                   imem_en;
  logic [INSN_WIDTH-1:0]  imem_rdata;
  logic [INSN_WIDTH-1:0]  insn;
  logic                   insn_valid;
  logic                   insn_ready;

  modport master (
    output IP, imem_addr, imem_en, insn, insn_valid,
    input  next_ip, imem_rdata, insn_ready
  );

  modport slave (
    input  IP, imem_addr, imem_en, insn, insn_valid,
    output next_ip, imem_rdata, insn_ready
  );

endinterface

`default_nettype wire

// File: rtl/ip_fetch_hold.sv
// ---------------------------------------------------------------------------
// ip_fetch_hold : selects live memory data or a held copy during stalls
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ip_fetch_hold #(
  parameter int INSN_WIDTH = ip_fetch_pkg::INSN_WIDTH
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  clear_i,
  input  wire logic                  capture_i,
  input  wire logic [INSN_WIDTH-1:0] rdata_i,
  output logic      [INSN_WIDTH-1:0] insn_o
);
  import ip_fetch_pkg::*;

  logic                  fresh_q, fresh_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;

  // clear: next presented word comes straight from memory.
  // capture: freeze the live word once, later reads are speculative junk.
  always_comb begin
    fresh_d = fresh_q;
    insn_d  = insn_q;
    if (clear_i) begin
      fresh_d = 1'b1;
    end else if (capture_i && fresh_q) begin
      insn_d  = rdata_i;
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fresh_q <= 1'b0;
      insn_q  <= '0;
    end else begin
      fresh_q <= fresh_d;
      insn_q  <= insn_d;
    end
  end

  assign insn_o = fresh_q ? rdata_i : insn_q;

endmodule

`default_nettype wire

// File: rtl/ip_fetch.sv
// ---------------------------------------------------------------------------
// ip_fetch : instruction-fetch stage with IP+1 prefetch, one-bubble redirects
// Optional IP_FETCH_STATS_EN adds saturating accept/bubble counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ip_fetch #(
  parameter int IADDR_WIDTH  = ip_fetch_pkg::IADDR_WIDTH,
  parameter int INSN_WIDTH   = ip_fetch_pkg::INSN_WIDTH,
  parameter int RESET_VECTOR = ip_fetch_pkg::RESET_VECTOR
) (
  input  wire logic clk,
  input  wire logic reset,
  ip_fetch_if.master bus
`ifdef IP_FETCH_STATS_EN
  ,
  output logic [ip_fetch_pkg::STAT_WIDTH-1:0] stat_accepts,
  output logic [ip_fetch_pkg::STAT_WIDTH-1:0] stat_bubbles
`endif
);
  import ip_fetch_pkg::*;

  state_e                 state_q, state_d;
  logic [IADDR_WIDTH-1:0] ip_q, ip_d;
  logic [IADDR_WIDTH-1:0] w_ip_plus1;
  logic                   w_accept;
  logic                   w_seq_hit;
  logic [IADDR_WIDTH-1:0] w_imem_addr;
  logic                   w_imem_en;
  logic                   w_insn_valid;
  logic [INSN_WIDTH-1:0]  w_insn;

  assign w_ip_plus1 = ip_q + IADDR_WIDTH'(1);
  assign w_accept   = (state_q == ST_VALID) && bus.insn_ready;
  assign w_seq_hit  = (bus.next_ip == w_ip_plus1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      ip_q    <= IADDR_WIDTH'(RESET_VECTOR);
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    case (state_q)
      ST_REQ:   state_d = ST_VALID;
      ST_VALID: begin
        if (w_accept) begin
          ip_d = bus.next_ip;
          // Any target other than the prefetched IP+1 (self-loop included) refetches.
          if (!w_seq_hit) state_d = ST_REQ;
        end
      end
      default:  state_d = ST_REQ;
    endcase
  end

  always_comb begin
    w_imem_addr  = ip_q;
    w_imem_en    = 1'b0;
    w_insn_valid = 1'b0;
    if (reset) begin
      w_imem_addr = IADDR_WIDTH'(RESET_VECTOR);
    end else begin
      case (state_q)
        ST_REQ: begin
          w_imem_addr = ip_q;
          w_imem_en   = 1'b1;
        end
        ST_VALID: begin
          w_imem_addr  = w_ip_plus1;
          w_imem_en    = 1'b1;
          w_insn_valid = 1'b1;
        end
        default: begin
          w_imem_addr = ip_q;
        end
      endcase
    end
  end

  ip_fetch_hold #(
    .INSN_WIDTH (INSN_WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_q == ST_REQ) || (w_accept && w_seq_hit)),
    .capture_i ((state_q == ST_VALID) && !bus.insn_ready),
    .rdata_i   (bus.imem_rdata),
    .insn_o    (w_insn)
  );

  assign bus.IP         = ip_q;
  assign bus.imem_addr  = w_imem_addr;
  assign bus.imem_en    = w_imem_en;
  assign bus.insn       = w_insn;
  assign bus.insn_valid = w_insn_valid;

`ifdef IP_FETCH_STATS_EN
  logic                  after_reset_q;
  logic [STAT_WIDTH-1:0] accepts_q;
  logic [STAT_WIDTH-1:0] bubbles_q;

  // The REQ right after reset is the cold start, not a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      after_reset_q <= 1'b1;
      accepts_q     <= '0;
      bubbles_q     <= '0;
    end else begin
      after_reset_q <= 1'b0;
      if (w_accept) accepts_q <= sat_inc(accepts_q);
      if ((state_q == ST_REQ) && !after_reset_q) bubbles_q <= sat_inc(bubbles_q);
    end
  end

  assign stat_accepts = accepts_q;
  assign stat_bubbles = bubbles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ip_fetch.sv
// ---------------------------------------------------------------------------
// tb_ip_fetch : directed stimulus with a queue scoreboard for ip_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ip_fetch;

  localparam int RV = 4;

  typedef struct packed {
    logic [9:0]  ip;
    logic [15:0] insn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] redir_from;
  logic [9:0] redir_to;
  logic       garbage;
  int         n_checks = 0;
  int         n_pass   = 0;
  exp_t       exp_q[$];

  always #5 clk = ~clk;

  ip_fetch_if bus ();

`ifdef IP_FETCH_STATS_EN
  logic [15:0] stat_accepts;
  logic [15:0] stat_bubbles;
`endif

  ip_fetch #(
    .RESET_VECTOR (RV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IP_FETCH_STATS_EN
    ,
    .stat_accepts (stat_accepts),
    .stat_bubbles (stat_bubbles)
`endif
  );

  // Memory: word k holds 0x1000+k; reads on stall edges return junk when asked.
  always @(posedge clk) begin
    if (bus.imem_en)
      bus.imem_rdata <= (garbage && !bus.insn_ready) ? 16'hDEAD
                                                     : 16'h1000 + 16'(bus.imem_addr);
  end

  always_comb begin
    if (bus.IP == redir_from) bus.next_ip = redir_to;
    else                      bus.next_ip = 10'(bus.IP + 10'd1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push(input logic [9:0] ip, input logic [15:0] insn);
    exp_t e;
    e.ip   = ip;
    e.insn = insn;
    exp_q.push_back(e);
  endtask

  task automatic wait_ip(input logic [9:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (bus.insn_valid && bus.IP == target) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_ip: IP %0h never presented, last IP %0h", target, bus.IP);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.insn_valid && bus.insn_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_accept: got IP %0h insn %0h, expected none", bus.IP, bus.insn);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("acc_ip", 32'(bus.IP), 32'(e.ip));
        check("acc_insn", 32'(bus.insn), 32'(e.insn));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.insn_ready = 1'b0;
    garbage        = 1'b0;
    redir_from     = 10'd5;
    redir_to       = 10'd9;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(bus.insn_valid), 0);
      check("rst_en", 32'(bus.imem_en), 0);
      check("rst_addr", 32'(bus.imem_addr), RV);
    end
    @(posedge clk); #1;
    reset          = 1'b0;
    bus.insn_ready = 1'b1;
    push(10'd4, 16'h1004); push(10'd5, 16'h1005); push(10'd9, 16'h1009);
    push(10'd10, 16'h100A); push(10'd11, 16'h100B);

    @(negedge clk);
    check("req_valid", 32'(bus.insn_valid), 0);
    check("req_en", 32'(bus.imem_en), 1);
    check("req_addr", 32'(bus.imem_addr), 4);
    check("req_ip", 32'(bus.IP), 4);
    @(negedge clk);
    check("first_valid", 32'(bus.insn_valid), 1);
    check("first_insn", 32'(bus.insn), 32'h1004);
    check("spec_addr", 32'(bus.imem_addr), 5);
    @(negedge clk);
    check("seq_valid", 32'(bus.insn_valid), 1);
    check("seq_ip", 32'(bus.IP), 5);
    check("seq_insn", 32'(bus.insn), 32'h1005);
    @(negedge clk);
    check("bubble_valid", 32'(bus.insn_valid), 0);
    check("bubble_addr", 32'(bus.imem_addr), 9);
    check("bubble_en", 32'(bus.imem_en), 1);
    @(posedge clk); #1;
    redir_from = 10'd11;
    redir_to   = 10'd0;
    push(10'd0, 16'h1000); push(10'd1, 16'h1001); push(10'd2, 16'h1002); push(10'd3, 16'h1003);
    @(negedge clk);
    check("redir_valid", 32'(bus.insn_valid), 1);
    check("redir_ip", 32'(bus.IP), 9);
    check("redir_insn", 32'(bus.insn), 32'h1009);

    wait_ip(10'd2);
    @(posedge clk); #1;
    bus.insn_ready = 1'b0;
    garbage        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.insn_valid), 1);
      check("stall_ip", 32'(bus.IP), 3);
      check("stall_insn", 32'(bus.insn), 32'h1003);
    end
    @(posedge clk); #1;
    bus.insn_ready = 1'b1;
    garbage        = 1'b0;
    redir_from     = 10'd4;
    redir_to       = 10'h3FE;
    push(10'd4, 16'h1004); push(10'h3FE, 16'h13FE); push(10'h3FF, 16'h13FF);
    push(10'd0, 16'h1000); push(10'd1, 16'h1001);
    @(negedge clk);
    check("release_insn", 32'(bus.insn), 32'h1003);
    @(negedge clk);
    check("release_next_valid", 32'(bus.insn_valid), 1);
    check("release_next_ip", 32'(bus.IP), 4);
    check("release_next_insn", 32'(bus.insn), 32'h1004);

    wait_ip(10'h3FF);
    check("wrap_spec_addr", 32'(bus.imem_addr), 0);
    @(posedge clk); #1;
    redir_from = 10'd1;
    redir_to   = 10'd7;
    @(negedge clk);
    check("wrap_valid", 32'(bus.insn_valid), 1);
    check("wrap_ip", 32'(bus.IP), 0);
    check("wrap_insn", 32'(bus.insn), 32'h1000);

    wait_ip(10'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(bus.insn_valid), 0);
    check("midrst_en", 32'(bus.imem_en), 0);
    check("midrst_addr", 32'(bus.imem_addr), RV);
    @(posedge clk); #1;
    reset      = 1'b0;
    redir_from = 10'd5;
    redir_to   = 10'd9;
    push(10'd4, 16'h1004); push(10'd5, 16'h1005); push(10'd9, 16'h1009); push(10'd10, 16'h100A);
    @(negedge clk);
    check("post_rst_ip", 32'(bus.IP), RV);
    check("post_rst_valid", 32'(bus.insn_valid), 0);
`ifdef IP_FETCH_STATS_EN
    check("stat_accepts_clr", 32'(stat_accepts), 0);
    check("stat_bubbles_clr", 32'(stat_bubbles), 0);
`endif
    @(negedge clk);
    check("post_rst_first_valid", 32'(bus.insn_valid), 1);
    check("post_rst_first_insn", 32'(bus.insn), 32'h1004);

    wait_ip(10'd9);
`ifdef IP_FETCH_STATS_EN
    check("stat_accepts", 32'(stat_accepts), 2);
    check("stat_bubbles", 32'(stat_bubbles), 1);
`endif
    wait_ip(10'd10);
    @(posedge clk); #1;
    bus.insn_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ip_fetch.md
Name: ip_fetch

Overview:
- Instruction-fetch stage of the Forth core.
- Owns the architectural IP register and drives the synchronous instruction memory (1-cycle read latency).
- Presents the fetched instruction and its IP downstream with a valid/ready handshake.
- Consumes next_ip, produced by the IP-select logic (ip_comb) from the current IP.
- Sequential flow runs at 1 instruction/cycle via speculative IP+1 prefetch; any non-sequential next_ip costs exactly one bubble.

Parameters:
- iaddr_width, 10, instruction address width (IP, memory address).
- insn_width, 16, instruction word width.
- reset_vector, 0, IP value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- IP  output  iaddr_width  current instruction pointer; feeds ip_comb.
- next_ip  input  iaddr_width  IP of the instruction after the one being accepted (ip_comb ip_result).
- imem_addr  output  iaddr_width  instruction memory read address.
- imem_en  output  1  instruction memory read enable.
- imem_rdata  input  insn_width  read data; valid the cycle after imem_en=1.
- insn  output  insn_width  instruction at IP.
- insn_valid  output  1  insn is valid.
- insn_ready  input  1  downstream accepts insn this cycle; next_ip must be valid whenever insn_valid & insn_ready.

Behaviour:
- State machine with two states:
  - REQ: issue a read of IP.
  - VALID: an instruction is presented.
- Internal registers:
  - fresh (1): insn is sourced directly from imem_rdata.
  - insn_q (insn_width): holding register.
- Reset, sync, active-high, dominates all other inputs:
  - IP=reset_vector, state=REQ, fresh=0, insn_q=0.
  - While reset is high: insn_valid=0, imem_en=0, imem_addr=reset_vector.
  - Reset asserted mid-stall or mid-redirect discards the in-flight read. First post-reset cycle is REQ.
- REQ:
  - imem_addr=IP, imem_en=1, insn_valid=0.
  - Next state VALID, fresh=1.
- VALID:
  - insn_valid=1.
  - insn = fresh ? imem_rdata : insn_q.
  - imem_addr=IP+1 (modulo 2^iaddr_width; all-ones wraps to 0), imem_en=1 (speculative).
- Accept (VALID & insn_ready): IP<=next_ip.
  - If next_ip == IP+1 (wrapped), the speculative read hits: stay VALID, fresh=1. Zero bubbles.
  - Else redirect: state<=REQ. One bubble cycle (insn_valid=0), then VALID with fresh=1.
- Stall (VALID & !insn_ready):
  - If fresh, insn_q<=imem_rdata; fresh<=0.
  - insn and IP stay stable for the whole stall. Continuing speculative reads are harmless because their data is ignored.
- next_ip is sampled only on accept cycles; it is ignored otherwise.
- Self-loop (next_ip == IP) counts as a redirect: one bubble, same instruction re-fetched.
- Latency from reset release:
  - first insn_valid two cycles after the reset-release edge.
  - Redirect-to-valid: 2 cycles from the accept edge.

Optional Feature:
- Macro IP_FETCH_STATS_EN.
- Defined:
  - adds outputs stat_accepts[15:0] and stat_bubbles[15:0].
  - stat_accepts increments on each accept.
  - stat_bubbles increments on each REQ cycle not immediately following reset.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ip_fetch_pkg holds:
  - state encoding (REQ=1'b0, VALID=1'b1);
  - default widths IADDR_WIDTH=10, INSN_WIDTH=16;
  - RESET_VECTOR=0;
  - stats counter width 16.
- One natural sub-module, ip_fetch_hold:
  - fresh flag, insn_q and the insn output mux;
  - inputs capture/clear; parameterised by insn_width.
- Wrap-compare and state machine stay in ip_fetch.

Test Plan:
- Reset then sequential stream:
  - Stimulus: reset 3 cycles, memory[k]=16'h1000+k, insn_ready=1, next_ip=IP+1.
  - Required: first insn_valid 2 cycles after release, insn=1000,1001,1002… one per cycle, imem_addr one ahead of IP.
- Redirect:
  - Stimulus: at IP=5, next_ip=9.
  - Required: one cycle insn_valid=0 with imem_addr=9, imem_en=1; next cycle IP=9, insn=16'h1009; then back-to-back.
- Stall:
  - Stimulus: insn_ready=0 for 4 cycles at IP=3 while the memory model returns garbage on non-IP addresses.
  - Required: insn holds 16'h1003, IP=3 throughout; on release, accept then insn=16'h1004 the next cycle with no bubble.
- Wrap:
  - Stimulus: IP=10'h3FF, next_ip=0.
  - Required: treated as sequential, zero bubbles, insn=memory[0].
- Reset mid-operation:
  - Stimulus: assert reset during a redirect's REQ cycle, with reset_vector=4.
  - Required: insn_valid=0 during reset, IP=4 after, first insn=16'h1004. With IP_FETCH_STATS_EN: counters=0 after reset, stat_bubbles=1 after one redirect.
